// File: rtl/ks_pipe_sub.sv
// ---------------------------------------------------------------------------
// ks_pipe_sub
//
// Pipelined Kogge-Stone subtractor. It computes diff = a - b as a + ~b + 1.
// The parallel-prefix carry network has one register per level. The black
// and grey prefix cells are the same as in the Kogge-Stone adders. The
// subtract carry-in is folded into bit 0 of the generate vector.
//
// Pipeline layout:
//   stage 0      : pre-process (p, g, carry-in fold, operand MSBs)
//   stages 1..L  : prefix levels, span 2^(k-1) at level k
//   output stage : sum bits, borrow and signed overflow
// The latency from acceptance to out_valid is L+2 cycles.
//
// A single global enable stalls the whole pipeline. The enable is low while
// an unconsumed result sits at the output.
//
// Parameter:
//   WIDTH     operand width. It must be a power of two and at least 4.
//
// Ports:
//   clk       clock, rising edge
//   rst       asynchronous active-high reset
//   in_valid  operand pair valid
//   in_ready  pair accepted this cycle if in_valid (combinational)
//   a, b      minuend, subtrahend
//   out_valid result valid
//   out_ready downstream accepts result
//   diff      a - b mod 2^WIDTH
//   bout      borrow out (a < b unsigned)
//   ovf       signed overflow
//
// Optional build macro KS_SUB_ADD_MODE_EN:
//   Adds the input port op, which travels with a/b (0 = add, 1 = subtract).
//   In add mode bout reports the carry out. Without the macro the block
//   always subtracts.
// ---------------------------------------------------------------------------
module ks_pipe_sub #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
`ifdef KS_SUB_ADD_MODE_EN
    input  logic             op,
`endif
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int L = $clog2(WIDTH);

    logic en;
    logic sub_in;

`ifdef KS_SUB_ADD_MODE_EN
    assign sub_in = op;
`else
    assign sub_in = 1'b1;
`endif

    // Per-stage pipeline state. Index 0 is the pre-process stage and
    // index k is prefix level k. The running propagate is only needed as
    // an input to the next level, so it stops at level L-1.
    logic             valid_reg [0:L];
    logic [WIDTH-1:0] g_reg     [0:L];
    logic [WIDTH-1:0] p_reg     [0:L-1];
    logic [WIDTH-1:0] pp_reg    [0:L];   // original bitwise propagate
    logic             amsb_reg  [0:L];
    logic             bmsb_reg  [0:L];
    logic             sub_reg   [0:L];

    logic             out_valid_reg;
    logic [WIDTH-1:0] diff_reg;
    logic             bout_reg;
    logic             ovf_reg;

    assign en        = !(out_valid_reg && !out_ready);
    assign in_ready  = en;
    assign out_valid = out_valid_reg;
    assign diff      = diff_reg;
    assign bout      = bout_reg;
    assign ovf       = ovf_reg;

    // ---------------- stage 0: pre-process ----------------
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] p_in;
    logic [WIDTH-1:0] g_in;

    always_comb begin
        b_eff = sub_in ? ~b : b;
        p_in  = a ^ b_eff;
        g_in  = a & b_eff;
        // Subtract has carry-in 1. Bit 0 then generates whenever it would
        // propagate, so the prefix network itself needs no carry-in input.
        g_in[0] = g_in[0] | (sub_in & p_in[0]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_reg[0] <= 1'b0;
            g_reg[0]     <= '0;
            p_reg[0]     <= '0;
            pp_reg[0]    <= '0;
            amsb_reg[0]  <= 1'b0;
            bmsb_reg[0]  <= 1'b0;
            sub_reg[0]   <= 1'b0;
        end else if (en) begin
            valid_reg[0] <= in_valid;
            g_reg[0]     <= g_in;
            p_reg[0]     <= p_in;
            pp_reg[0]    <= p_in;
            amsb_reg[0]  <= a[WIDTH-1];
            bmsb_reg[0]  <= b[WIDTH-1];
            sub_reg[0]   <= sub_in;
        end
    end

    // ---------------- stages 1..L: prefix levels ----------------
    for (genvar gi = 1; gi <= L; gi++) begin : g_lvl
        localparam int D = 1 << (gi - 1);

        logic [WIDTH-1:0] g_nxt;

        // Shifting in zeros below bit D makes bits i < D pass through
        // unchanged (g | p & 0 = g).
        assign g_nxt = g_reg[gi-1]
                     | (p_reg[gi-1] & {g_reg[gi-1][WIDTH-1-D:0], {D{1'b0}}});

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                valid_reg[gi] <= 1'b0;
                g_reg[gi]     <= '0;
                pp_reg[gi]    <= '0;
                amsb_reg[gi]  <= 1'b0;
                bmsb_reg[gi]  <= 1'b0;
                sub_reg[gi]   <= 1'b0;
            end else if (en) begin
                valid_reg[gi] <= valid_reg[gi-1];
                g_reg[gi]     <= g_nxt;
                pp_reg[gi]    <= pp_reg[gi-1];
                amsb_reg[gi]  <= amsb_reg[gi-1];
                bmsb_reg[gi]  <= bmsb_reg[gi-1];
                sub_reg[gi]   <= sub_reg[gi-1];
            end
        end

        // The last level feeds only the sum stage, which needs no group
        // propagate, so no P register is built for it.
        if (gi < L) begin : g_prop
            logic [WIDTH-1:0] p_nxt;

            // Shifting in ones below bit D passes P through unchanged there.
            assign p_nxt = p_reg[gi-1]
                         & {p_reg[gi-1][WIDTH-1-D:0], {D{1'b1}}};

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    p_reg[gi] <= '0;
                end else if (en) begin
                    p_reg[gi] <= p_nxt;
                end
            end
        end
    end

    // ---------------- output stage ----------------
    logic [WIDTH-1:0] carry_in_vec;
    logic [WIDTH-1:0] diff_nxt;
    logic             bout_nxt;
    logic             ovf_nxt;

    always_comb begin
        // The carry into bit i is the group generate of bits i-1..0. Bit 0
        // sees the raw carry-in: 1 for subtract, 0 for add.
        carry_in_vec = {g_reg[L][WIDTH-2:0], sub_reg[L]};
        diff_nxt     = pp_reg[L] ^ carry_in_vec;
        bout_nxt     = sub_reg[L] ? ~g_reg[L][WIDTH-1] : g_reg[L][WIDTH-1];
        if (sub_reg[L]) begin
            ovf_nxt = (amsb_reg[L] != bmsb_reg[L])
                   && (diff_nxt[WIDTH-1] != amsb_reg[L]);
        end else begin
            ovf_nxt = (amsb_reg[L] == bmsb_reg[L])
                   && (diff_nxt[WIDTH-1] != amsb_reg[L]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            diff_reg      <= '0;
            bout_reg      <= 1'b0;
            ovf_reg       <= 1'b0;
        end else if (en) begin
            out_valid_reg <= valid_reg[L];
            diff_reg      <= diff_nxt;
            bout_reg      <= bout_nxt;
            ovf_reg       <= ovf_nxt;
        end
    end

endmodule

// File: tb/tb_ks_pipe_sub.sv
// ---------------------------------------------------------------------------
// tb_ks_pipe_sub
//
// Self-checking bench for ks_pipe_sub with WIDTH = 16. Expected results come
// from an arithmetic reference model. The model uses wide unsigned and
// signed integer math. Outputs are sampled one time unit after the rising
// edge or on the falling edge. Set KS_SUB_ADD_MODE_EN to exercise add mode.
// ---------------------------------------------------------------------------
module tb_ks_pipe_sub;

    localparam int W   = 16;
    localparam int LAT = 6;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    ks_pipe_sub #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef KS_SUB_ADD_MODE_EN
        .op        (op),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .ovf       (ovf)
    );

    // Reference result {diff, bout/carry, ovf}. sub = 1 subtracts, 0 adds.
    function automatic logic [W+1:0] ref_model(input logic [W-1:0] x,
                                               input logic [W-1:0] y,
                                               input logic sub);
        int         sx;
        int         sy;
        int         r;
        logic [W:0] wide;
        logic       cb;
        logic       ov;
        sx = int'($signed(x));
        sy = int'($signed(y));
        r  = sub ? (sx - sy) : (sx + sy);
        wide = sub ? ({1'b0, x} - {1'b0, y}) : ({1'b0, x} + {1'b0, y});
        cb = sub ? (x < y) : wide[W];
        ov = (r > ((1 << (W - 1)) - 1)) || (r < -(1 << (W - 1)));
        return {wide[W-1:0], cb, ov};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one pair into an idle pipeline with out_ready = 1. It returns
    // the cycle count from the acceptance edge to out_valid (capped at 20)
    // and the observed result.
    task automatic send_one(input logic [W-1:0] x, input logic [W-1:0] y,
                            input logic o, output int lat,
                            output logic [W+1:0] res);
        a = x; b = y; op = o; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        res = {diff, bout, ovf};
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; op = 1'b1;
        repeat (2) tick();
        vectors++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL reset out_valid: got %b want 0", out_valid);
        end
        vectors++;
        if (diff !== '0) begin
            errors++; $display("FAIL reset diff: got %h want 0000", diff);
        end
        vectors++;
        if ({bout, ovf} !== 2'b00) begin
            errors++; $display("FAIL reset bout/ovf: got %b%b want 00", bout, ovf);
        end
        vectors++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset in_ready: got %b want 1", in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
        $display("reset: checked idle outputs");
    endtask

    typedef struct {
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic         o;
        logic [W-1:0] d;
        logic         bo;
        logic         ov;
    } dcase_t;

    task automatic test_directed();
        dcase_t       cases [5];
        int           n;
        int           lat;
        logic [W+1:0] res;
        cases[0] = '{16'h1234, 16'h0034, 1'b1, 16'h1200, 1'b0, 1'b0};
        cases[1] = '{16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        cases[2] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b0, 1'b1};
        cases[3] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        cases[4] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
`ifdef KS_SUB_ADD_MODE_EN
        n = 5;
`else
        n = 3;
`endif
        for (int i = 0; i < n; i++) begin
            send_one(cases[i].x, cases[i].y, cases[i].o, lat, res);
            vectors++;
            if (lat !== LAT) begin
                errors++;
                $display("FAIL directed[%0d] latency: got %0d want %0d", i, lat, LAT);
            end
            vectors++;
            if (res[W+1:2] !== cases[i].d) begin
                errors++;
                $display("FAIL directed[%0d] diff: got %h want %h", i, res[W+1:2], cases[i].d);
            end
            vectors++;
            if (res[1] !== cases[i].bo) begin
                errors++;
                $display("FAIL directed[%0d] bout: got %b want %b", i, res[1], cases[i].bo);
            end
            vectors++;
            if (res[0] !== cases[i].ov) begin
                errors++;
                $display("FAIL directed[%0d] ovf: got %b want %b", i, res[0], cases[i].ov);
            end
            $display("directed[%0d]: a=%h b=%h op=%b -> diff=%h bout=%b ovf=%b lat=%0d",
                     i, cases[i].x, cases[i].y, cases[i].o, res[W+1:2], res[1], res[0], lat);
        end
    endtask

    task automatic test_back_to_back();
        logic [W+1:0] exp_q [$];
        logic [W+1:0] want;
        logic [W+2:0] held;
        logic         stalled_prev;
        int           idx;
        int           got;
        int           cycle;
        idx = 0; got = 0; cycle = 0; stalled_prev = 1'b0; held = '0;
        op = 1'b1;
        while (got < 8 && cycle < 200) begin
            in_valid  = (idx < 8);
            a         = W'(idx * 16'h1111);
            b         = W'(idx);
            out_ready = !(cycle >= 7 && cycle < 10);
            @(negedge clk);
            vectors++;
            if (in_ready !== !(out_valid && !out_ready)) begin
                errors++;
                $display("FAIL b2b in_ready cycle %0d: got %b want %b",
                         cycle, in_ready, !(out_valid && !out_ready));
            end
            if (stalled_prev) begin
                vectors++;
                if ({out_valid, diff, bout, ovf} !== held) begin
                    errors++;
                    $display("FAIL b2b hold cycle %0d: got %h want %h",
                             cycle, {out_valid, diff, bout, ovf}, held);
                end
            end
            stalled_prev = out_valid && !out_ready;
            held = {out_valid, diff, bout, ovf};
            if (out_valid && out_ready) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL b2b extra result: got %h want none", {diff, bout, ovf});
                end else begin
                    want = exp_q.pop_front();
                    if ({diff, bout, ovf} !== want) begin
                        errors++;
                        $display("FAIL b2b result %0d: got %h want %h", got, {diff, bout, ovf}, want);
                    end
                end
                $display("b2b: result %0d diff=%h bout=%b ovf=%b", got, diff, bout, ovf);
                got++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_model(a, b, op));
                idx++;
            end
            tick();
            cycle++;
        end
        in_valid = 1'b0;
        vectors++;
        if (got != 8 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL b2b count: got %0d results want 8 (pending %0d)", got, exp_q.size());
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            vectors++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL b2b duplicate: got out_valid=%b want 0 (idle cycle %0d)", out_valid, i);
            end
            tick();
        end
    endtask

    task automatic test_reset_flight();
        int           lat;
        int           waited;
        logic         seen;
        logic [W+1:0] res;
        logic [W+1:0] want;
        out_ready = 1'b0; op = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; a = W'($urandom); b = W'($urandom);
            tick();
        end
        in_valid = 1'b0;
        waited = 0;
        while (!out_valid && waited < 20) begin
            tick();
            waited++;
        end
        vectors++;
        if (out_valid !== 1'b1) begin
            errors++; $display("FAIL flight fill: got out_valid=%b want 1", out_valid);
        end
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if ({out_valid, diff, bout, ovf} !== '0) begin
            errors++;
            $display("FAIL flight async reset: got valid=%b diff=%h bout=%b ovf=%b want all 0",
                     out_valid, diff, bout, ovf);
        end
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        vectors++;
        if (seen !== 1'b0) begin
            errors++; $display("FAIL flight discarded: got out_valid=1 want none");
        end
        send_one(16'h4321, 16'h1234, 1'b1, lat, res);
        want = ref_model(16'h4321, 16'h1234, 1'b1);
        vectors++;
        if (lat !== LAT || res !== want) begin
            errors++;
            $display("FAIL flight post-reset: got lat=%0d res=%h want lat=%0d res=%h", lat, res, LAT, want);
        end
        $display("flight: reset discarded 3 ops, next result lat=%0d diff=%h", lat, res[W+1:2]);
    endtask

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            2:       return 16'h8000;
            3:       return 16'h7FFF;
            default: return W'($urandom);
        endcase
    endfunction

    task automatic test_random();
        logic [W+1:0] exp_q [$];
        logic [W+1:0] want;
        logic         pending;
        int           accepted;
        int           cycle;
        int           checked;
        accepted = 0; cycle = 0; checked = 0; pending = 1'b0;
        in_valid = 1'b0;
        while ((accepted < 10000 || exp_q.size() != 0) && cycle < 60000) begin
            if (!pending) begin
                in_valid = (accepted < 10000) && ($urandom_range(0, 3) != 0);
                a = pick_operand();
                b = pick_operand();
`ifdef KS_SUB_ADD_MODE_EN
                op = 1'($urandom_range(0, 1));
`else
                op = 1'b1;
`endif
            end
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (out_valid && out_ready) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL random extra result: got %h want none", {diff, bout, ovf});
                end else begin
                    want = exp_q.pop_front();
                    if ({diff, bout, ovf} !== want) begin
                        errors++;
                        $display("FAIL random result %0d: got %h want %h", checked, {diff, bout, ovf}, want);
                    end
                end
                checked++;
            end
            pending = in_valid && !in_ready;
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_model(a, b, op));
                accepted++;
            end
            tick();
            cycle++;
        end
        in_valid = 1'b0;
        vectors++;
        if (accepted != 10000 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL random drain: got %0d accepted, %0d pending want 10000, 0",
                     accepted, exp_q.size());
        end
        $display("random: %0d pairs accepted, %0d results checked in %0d cycles",
                 accepted, checked, cycle);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_flight();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
